// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage: widths, opcodes and FSM encoding.
package alu_pkg;

   localparam int ALU_DATA_W     = 16;
   localparam int ALU_REG_SEL_W  = 3;
   localparam int ALU_MUL_CYCLES = 16;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_MUL_BUSY = 1'b1
   } state_t;

endpackage

// File: rtl/alu_shift_add_mul.sv
// Iterative shift-add multiplier: one partial product per step, done on the last step.
module alu_shift_add_mul
   import alu_pkg::*;
#(
   parameter int DATA_W     = ALU_DATA_W,
   parameter int MUL_CYCLES = ALU_MUL_CYCLES
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  step,
   input  logic [DATA_W-1:0]     a,
   input  logic [DATA_W-1:0]     b,
   output logic                  done,
   output logic [2*DATA_W-1:0]   product
);

   localparam int CNT_W = $clog2(MUL_CYCLES);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(MUL_CYCLES - 1);

   logic [2*DATA_W-1:0] mcand;
   logic [DATA_W-1:0]   mplier;
   logic [2*DATA_W-1:0] acc;
   logic [2*DATA_W-1:0] acc_next;
   logic [CNT_W-1:0]    count;

   // product is the accumulator after this cycle's add, so the top can
   // register the final value on the same edge the last step happens.
   always_comb begin
      acc_next = mplier[0] ? (acc + mcand) : acc;
      product  = acc_next;
      done     = step && (count == LAST);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         count  <= '0;
      end else if (start) begin
         mcand  <= {{DATA_W{1'b0}}, a};
         mplier <= b;
         acc    <= '0;
         count  <= '0;
      end else if (step) begin
         acc    <= acc_next;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         count  <= done ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/alu_execute_stage.sv
// Execute stage feeding the 8x16 register bank; single-cycle ops plus a 16-cycle MUL.
// Define ALU_FAST_MUL_EN to build MUL as a single-cycle combinational multiplier instead.
module alu_execute_stage
   import alu_pkg::*;
#(
   parameter int DATA_W     = ALU_DATA_W,
   parameter int REG_SEL_W  = ALU_REG_SEL_W,
   parameter int MUL_CYCLES = ALU_MUL_CYCLES
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 op_valid,
   output logic                 op_ready,
   input  logic [2:0]           opcode,
   input  logic [DATA_W-1:0]    src1,
   input  logic [DATA_W-1:0]    src2,
   input  logic [REG_SEL_W-1:0] dest_sel_in,
   output logic [DATA_W-1:0]    ALU_result,
   output logic [REG_SEL_W-1:0] destreg_sel,
   output logic                 result_valid,
   output logic                 zero_flag,
   output logic                 carry_flag
);

   localparam int SH_W = $clog2(DATA_W);

   // Handshake: an op transfers on a rising edge with op_valid && op_ready;
   // operands are sampled only on that edge and op_valid is ignored otherwise.
   logic accept;
   logic slow_mul;
   logic mul_done;
   logic [DATA_W-1:0]    mul_res;
   logic                 mul_carry;
   logic [REG_SEL_W-1:0] mul_dest;

   logic [DATA_W-1:0] alu_res;
   logic              alu_carry;
   logic [DATA_W:0]   sum;
   logic [DATA_W:0]   shl;
   logic [DATA_W:0]   shr;

   assign accept = op_valid && op_ready;

`ifdef ALU_FAST_MUL_EN
   logic [2*DATA_W-1:0] fast_prod;

   assign fast_prod = {{DATA_W{1'b0}}, src1} * {{DATA_W{1'b0}}, src2};
   assign op_ready  = 1'b1;
   assign slow_mul  = 1'b0;
   assign mul_done  = 1'b0;
   assign mul_res   = '0;
   assign mul_carry = 1'b0;
   assign mul_dest  = '0;
`else
   state_t              state;
   state_t              state_next;
   logic                mul_start;
   logic [2*DATA_W-1:0] product;

   assign slow_mul  = (opcode == OP_MUL);
   assign mul_start = accept && slow_mul;

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:     if (mul_start) state_next = ST_MUL_BUSY;
         ST_MUL_BUSY: if (mul_done)  state_next = ST_IDLE;
         default:     state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      op_ready = (state == ST_IDLE);
   end

   alu_shift_add_mul #(
      .DATA_W     (DATA_W),
      .MUL_CYCLES (MUL_CYCLES)
   ) u_mul (
      .clk     (clk),
      .reset   (reset),
      .start   (mul_start),
      .step    (state == ST_MUL_BUSY),
      .a       (src1),
      .b       (src2),
      .done    (mul_done),
      .product (product)
   );

   // Destination is parked here so destreg_sel keeps showing the last result until MUL ends.
   always_ff @(posedge clk) begin
      if (reset)          mul_dest <= '0;
      else if (mul_start) mul_dest <= dest_sel_in;
   end

   assign mul_res   = product[DATA_W-1:0];
   assign mul_carry = |product[2*DATA_W-1:DATA_W];
`endif

   // Shifts run one bit wider so the last bit shifted out lands in bit DATA_W / bit 0.
   always_comb begin
      alu_res   = '0;
      alu_carry = 1'b0;
      sum = {1'b0, src1} + {1'b0, src2};
      shl = {1'b0, src1} << src2[SH_W-1:0];
      shr = {src1, 1'b0} >> src2[SH_W-1:0];
      case (opcode)
         OP_ADD: begin alu_res = sum[DATA_W-1:0]; alu_carry = sum[DATA_W]; end
         OP_SUB: begin alu_res = src1 - src2;     alu_carry = (src1 < src2); end
         OP_AND: alu_res = src1 & src2;
         OP_OR:  alu_res = src1 | src2;
         OP_XOR: alu_res = src1 ^ src2;
         OP_SHL: begin alu_res = shl[DATA_W-1:0]; alu_carry = shl[DATA_W]; end
         OP_SHR: begin alu_res = shr[DATA_W:1];   alu_carry = shr[0]; end
`ifdef ALU_FAST_MUL_EN
         OP_MUL: begin
            alu_res   = fast_prod[DATA_W-1:0];
            alu_carry = |fast_prod[2*DATA_W-1:DATA_W];
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ALU_result   <= '0;
         destreg_sel  <= '0;
         result_valid <= 1'b0;
         zero_flag    <= 1'b0;
         carry_flag   <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         if (accept && !slow_mul) begin
            ALU_result   <= alu_res;
            destreg_sel  <= dest_sel_in;
            zero_flag    <= (alu_res == '0);
            carry_flag   <= alu_carry;
            result_valid <= 1'b1;
         end
         if (mul_done) begin
            ALU_result   <= mul_res;
            destreg_sel  <= mul_dest;
            zero_flag    <= (mul_res == '0);
            carry_flag   <= mul_carry;
            result_valid <= 1'b1;
         end
      end
   end

endmodule
